// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the M-extension sequencer: opcodes, FSM encoding and
// the opcode classification helpers used by the sequencer and its bench.
package mdu_seq_pkg;

  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;
  localparam logic [4:0] ALU_MULW   = 5'h18;
  localparam logic [4:0] ALU_DIVW   = 5'h19;
  localparam logic [4:0] ALU_DIVUW  = 5'h1A;
  localparam logic [4:0] ALU_REMW   = 5'h1B;
  localparam logic [4:0] ALU_REMUW  = 5'h1C;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_PREP = 2'd1,
    MDU_CALC = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};
  endfunction

  // MULW only needs the low product half, so it runs on unsigned magnitudes.
  function automatic logic is_signed_a(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

  function automatic logic is_word(input logic [4:0] op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic want_hi_or_rem(input logic [4:0] op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

endpackage

// File: rtl/mdu_seq_iter.sv
// One step of the shared datapath: shift-add for multiply (right shift),
// restoring shift-subtract for divide (left shift, quotient bit into bit 0).
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [2*XLEN:0] shl;

  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    shl  = {acc_i, 1'b0};
    // Partial remainder stays below the divisor, so bit XLEN of diff is the borrow.
    diff = shl[2*XLEN:XLEN] - {1'b0, opnd_i};
    if (div_i) begin
      acc_o = diff[XLEN] ? shl[2*XLEN-1:0]
                         : {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MUL/DIV/REM sequencer beside the EX-stage ALU.
// Build option MDU_FAST_MUL_EN: multiplies finish in PREP with a single-cycle product.
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [4:0]      aluop_i,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      state_o
);
  import mdu_seq_pkg::*;

  // Handshake: start_i is taken only in IDLE (and not with flush_i); the
  // requester holds start_i/aluop_i/operands until done_o, which pulses one
  // cycle with result_o valid; busy_o is high from acceptance through FIX.

  mdu_state_e        state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [XLEN-1:0]   corner_res_q, corner_res_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [5:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d, corner_q, corner_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              word, sgn_a, sgn_b, mul, hi;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, a_sx32, dividend;
  logic              neg_a, neg_b, div0, ovf;
  logic [5:0]        last_cnt;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   mul_res, div_val, div_fix, div_res, fix_res;

  assign word   = is_word(op_q);
  assign sgn_a  = is_signed_a(op_q);
  assign sgn_b  = is_signed_b(op_q);
  assign mul    = is_mul(op_q);
  assign hi     = want_hi_or_rem(op_q);

  assign a_ext  = word ? {{(XLEN-32){a_q[31] & sgn_a}}, a_q[31:0]} : a_q;
  assign b_ext  = word ? {{(XLEN-32){b_q[31] & sgn_b}}, b_q[31:0]} : b_q;
  assign neg_a  = sgn_a & a_ext[XLEN-1];
  assign neg_b  = sgn_b & b_ext[XLEN-1];
  assign mag_a  = neg_a ? -a_ext : a_ext;
  assign mag_b  = neg_b ? -b_ext : b_ext;
  assign a_sx32 = {{(XLEN-32){a_q[31]}}, a_q[31:0]};
  assign dividend = word ? a_sx32 : a_q;

  assign div0 = ~mul & (word ? (b_q[31:0] == 32'd0) : (b_q == '0));
  assign ovf  = ~mul & sgn_a &
                (word ? (a_q[31:0] == 32'h8000_0000 && b_q[31:0] == 32'hFFFF_FFFF)
                      : (a_q == {1'b1, {(XLEN-1){1'b0}}} && (&b_q)));

  assign last_cnt = word ? 6'd31 : 6'd63;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (~mul),
    .acc_o  (acc_step)
  );

  // A word multiply run for 32 steps leaves its product at bits [95:32].
  always_comb begin
    mul_full = neg_q ? -acc_q : acc_q;
    mul_res  = word ? {{(XLEN-32){acc_q[63]}}, acc_q[63:32]}
                    : (hi ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0]);
    div_val  = hi ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = neg_q ? -div_val : div_val;
    div_res  = word ? {{(XLEN-32){div_fix[31]}}, div_fix[31:0]} : div_fix;
    fix_res  = corner_q ? corner_res_q : (mul ? mul_res : div_res);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    corner_d     = corner_q;
    corner_res_d = corner_res_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = aluop_i;
          a_d     = srcA_i;
          b_d     = srcB_i;
          busy_d  = 1'b1;
          state_d = MDU_PREP;
        end
      end
      MDU_PREP: begin
        cnt_d        = 6'd0;
        neg_d        = (mul || !hi) ? (neg_a ^ neg_b) : neg_a;
        corner_d     = div0 | ovf;
        corner_res_d = div0 ? (hi ? dividend : '1) : (hi ? '0 : dividend);
        opnd_d       = mul ? mag_a : mag_b;
        if (mul)       acc_d = {{XLEN{1'b0}}, mag_b};
        else if (word) acc_d = {{XLEN{1'b0}}, mag_a[31:0], 32'd0};
        else           acc_d = {{XLEN{1'b0}}, mag_a};
        state_d      = (div0 | ovf) ? MDU_FIX : MDU_CALC;
`ifdef MDU_FAST_MUL_EN
        if (mul) begin
          acc_d   = word ? (fast_prod << 32) : fast_prod;
          state_d = MDU_FIX;
        end
`endif
      end
      MDU_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == last_cnt) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    if (flush_i) begin
      state_d  = MDU_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= MDU_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      corner_q     <= 1'b0;
      corner_res_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      corner_q     <= corner_d;
      corner_res_q <= corner_res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign state_o  = state_q;
  assign stall_o  = busy_q | (start_i & (state_q == MDU_IDLE));

endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomised checks of mdu_seq with a result scoreboard.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic [4:0]  aluop_i;
  logic [63:0] srcA_i, srcB_i;
  logic        flush_i;
  logic        busy_o, stall_o, done_o;
  logic [63:0] result_o;
  logic [1:0]  state_o;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;
  logic [4:0]  rand_ops [0:7];

  mdu_seq #(.XLEN(64)) dut (
    .clock    (clock),
    .reset    (reset),
    .start_i  (start_i),
    .aluop_i  (aluop_i),
    .srcA_i   (srcA_i),
    .srcB_i   (srcB_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .state_o  (state_o)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op, input bit corner);
    if (corner) return 2;
`ifdef MDU_FAST_MUL_EN
    if (is_mul(op)) return 2;
`endif
    return is_word(op) ? 34 : 66;
  endfunction

  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa128, sb128, sp;
    logic [127:0]        up;
    logic signed [63:0]  sa, sb;
    sa = a;
    sb = b;
    sa128 = {{64{a[63]}}, a};
    sb128 = (op == ALU_MULHSU) ? {64'd0, b} : {{64{b[63]}}, b};
    sp = sa128 * sb128;
    up = {64'd0, a} * {64'd0, b};
    case (op)
      ALU_MUL:    return a * b;
      ALU_MULH:   return sp[127:64];
      ALU_MULHSU: return sp[127:64];
      ALU_MULHU:  return up[127:64];
      ALU_DIV:    return sa / sb;
      ALU_DIVU:   return a / b;
      ALU_REM:    return sa % sb;
      default:    return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat_exp, input bit toggle);
    int lat;
    bit seen;
    exp_q.push_back(exp);
    @(negedge clock);
    aluop_i = op; srcA_i = a; srcB_i = b; start_i = 1'b1;
    #1 check("stall_start", stall_o, 1'b1);
    @(posedge clock);
    #1 check("busy_e0", busy_o, 1'b1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clock);
      lat++;
      #1;
      if (done_o) seen = 1'b1;
      else if (toggle) start_i = 1'($urandom_range(0, 1));
    end
    start_i = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check("latency", 64'(lat), 64'(lat_exp));
      check("busy_at_done", busy_o, 1'b0);
      #1 check("stall_at_done", stall_o, 1'b0);
      last_exp = exp_q.pop_front();
      check("result", result_o, last_exp);
      @(posedge clock);
      #1 check("done_one_cycle", done_o, 1'b0);
      check("result_held", result_o, last_exp);
    end
  endtask

  task automatic reset_mid_calc();
    @(negedge clock);
    aluop_i = ALU_DIVU; srcA_i = 64'd1000; srcB_i = 64'd3; start_i = 1'b1;
    repeat (12) @(posedge clock);
    #3;
    reset = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_state", state_o, MDU_IDLE);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_result", result_o, 64'd0);
    last_exp = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int dones;
    logic [63:0] ra, rb;
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    aluop_i = ALU_MUL; srcA_i = '0; srcB_i = '0;
    #1;
    check("init_state", state_o, MDU_IDLE);
    check("init_busy", busy_o, 1'b0);
    check("init_done", done_o, 1'b0);
    check("init_result", result_o, 64'd0);
    check("init_stall", stall_o, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_op(ALU_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, lat_of(ALU_DIV, 0), 0);
    run_op(ALU_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, lat_of(ALU_REM, 0), 0);
    reset_mid_calc();

    run_op(ALU_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op(ALU_REMU, 64'h1234, 64'd0, 64'h1234, 2, 0);
    reset_mid_calc();

    run_op(ALU_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 0);
    run_op(ALU_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
    run_op(ALU_DIVW, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2, 0);
    reset_mid_calc();

    run_op(ALU_MULH, '1, '1, 64'd0, lat_of(ALU_MULH, 0), 0);
    run_op(ALU_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, lat_of(ALU_MULHU, 0), 0);
    run_op(ALU_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, lat_of(ALU_MULW, 0), 0);
    run_op(ALU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
    run_op(ALU_REMUW, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 2, 0);

    // Flush in the 10th CALC cycle
    @(negedge clock);
    aluop_i = ALU_DIV; srcA_i = -64'sd100; srcB_i = 64'd7; start_i = 1'b1;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1 check("flush_pre_state", state_o, MDU_CALC);
    flush_i = 1'b1;
    @(posedge clock);
    #1;
    check("flush_state", state_o, MDU_IDLE);
    check("flush_busy", busy_o, 1'b0);
    check("flush_done", done_o, 1'b0);
    check("flush_result", result_o, last_exp);
    flush_i = 1'b0; start_i = 1'b0;
    dones = 0;
    repeat (80) begin
      @(posedge clock);
      #1 if (done_o) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);

    // Start and flush together in IDLE
    @(negedge clock);
    aluop_i = ALU_DIVU; srcA_i = 64'd50; srcB_i = 64'd0; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clock);
    #1;
    check("startflush_state", state_o, MDU_IDLE);
    check("startflush_busy", busy_o, 1'b0);
    start_i = 1'b0; flush_i = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clock);
      #1 if (done_o) dones++;
    end
    check("startflush_no_done", 64'(dones), 64'd0);
    reset_mid_calc();

    // start_i toggling while busy must not launch anything extra
    run_op(ALU_DIVU, 64'd100, 64'd7, 64'd14, 66, 1);
    dones = 0;
    repeat (70) begin
      @(posedge clock);
      #1 if (done_o) dones++;
    end
    check("toggle_single_done", 64'(dones), 64'd0);
    reset_mid_calc();

    rand_ops[0] = ALU_MUL;  rand_ops[1] = ALU_MULH; rand_ops[2] = ALU_MULHSU; rand_ops[3] = ALU_MULHU;
    rand_ops[4] = ALU_DIV;  rand_ops[5] = ALU_DIVU; rand_ops[6] = ALU_REM;    rand_ops[7] = ALU_REMU;
    for (int i = 0; i < 8; i++) begin
      ra = {32'($urandom), 32'($urandom)};
      rb = {32'($urandom), 32'($urandom)};
      if (i >= 6) rb = rb >> $urandom_range(8, 60);
      if (rb == '0) rb = 64'd1;
      if (ra == 64'h8000_0000_0000_0000 && (&rb)) rb = 64'd5;
      run_op(rand_ops[i], ra, rb, model(rand_ops[i], ra, rb), lat_of(rand_ops[i], 0), 0);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle sequencer for the M-extension operations (MUL*/DIV*/REM*, including the RV64 W forms) that the decode stage marks with `ALU_MUL`…`ALU_REMUW` aluops. It sits beside the EX-stage ALU. It accepts one operation at a time, iterates a shared shift-add/shift-subtract datapath, and holds the pipeline until the result is ready. It also handles the RISC-V divide corner cases without iterating.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request an operation; sampled only in IDLE.
- `aluop_i`  in  5  operation code, one of the `ALU_` M-extension codes.
- `srcA_i`  in  XLEN  rs1 value (multiplicand/dividend).
- `srcB_i`  in  XLEN  rs2 value (multiplier/divisor).
- `flush_i`  in  1  abort the current operation (branch flush or exception).
- `busy_o`  out  1  an operation is in flight (registered).
- `stall_o`  out  1  combinational; equals `busy_o | (start_i & IDLE)`; freezes ID/EX.
- `done_o`  out  1  single-cycle pulse: `result_o` is valid.
- `result_o`  out  XLEN  result; held from `done_o` until the next accepted start.

## Operation
- States:
  - IDLE: wait for a request.
  - PREP: latch operands, take absolute values for signed operations, zero- or sign-extend the low 32 bits for W operations, detect corner cases.
  - CALC: iterate the datapath.
  - FIX: apply result sign, select hi/lo half, sign-extend 32→64 for W operations; register the result, pulse `done_o`.
- Transitions:
  - IDLE → PREP on `start_i & ~flush_i`.
  - PREP → FIX on a corner case, else PREP → CALC.
  - CALC → FIX when the iteration counter reaches N−1.
  - FIX → IDLE.
- N = 64 for 64-bit operations, 32 for W operations. The iteration counter is 6 bits, cleared in PREP.
- Multiply: unsigned magnitudes, shift-add, 2·XLEN-bit product register.
  - MUL/MULW return the low half.
  - MULH/MULHU/MULHSU return the high half.
  - MULHSU treats srcB as unsigned.
  - The sign fix is a two's-complement negate of the full 128-bit product.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Corner cases, decided in PREP, skip CALC:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
  - For W operations, both corner cases are evaluated on 32-bit values and the result is sign-extended.
- `start_i` while busy is ignored. The requester must hold `start_i` and its operands until `done_o`.
- `flush_i` in any state: next state is IDLE, no `done_o`, `result_o` unchanged. `flush_i` together with `start_i` in IDLE: the flush wins and the request is dropped.

## Timing
- Reset values: state = IDLE, `busy_o` = 0, `done_o` = 0, `result_o` = 0, counter = 0. Reset during an operation aborts it immediately and asynchronously.
- With the start accepted at edge E0:
  - `busy_o` is high from E0 through the FIX edge.
  - `done_o` is high for the one cycle following edge E0+N+2.
  - Corner cases: `done_o` follows edge E0+2.
- `busy_o` falls on the same edge `done_o` rises. The stage therefore releases the stall and consumes `result_o` in the `done_o` cycle.
- Back-to-back operations: a new start can be accepted in the `done_o` cycle (state IDLE).

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - Multiplies compute a single-cycle XLEN×XLEN product in PREP using a signed/unsigned `*` and go PREP → FIX. Multiply latency is 2.
  - Divides are unchanged.
- Not defined: multiplies iterate in CALC like divides, with latency N+2.

## Structure
- Shared definitions file holds:
  - the `ALU_` M-extension opcode constants;
  - state encodings `MDU_IDLE/PREP/CALC/FIX` (2 bits);
  - helper predicates `is_mul`, `is_signed_a`, `is_signed_b`, `is_word`, `want_hi_or_rem`.
- One sub-module, `mdu_iter`, holds the per-cycle step:
  - input: accumulator, operand, mode;
  - output: next accumulator;
  - add-or-subtract-and-shift only.
- The sequencer owns the FSM, counter, sign and fix logic.

## Test plan
- Directed scenarios, each with a reset asserted mid-CALC afterwards (expect IDLE, `done_o` = 0, `result_o` = 0 immediately):
  - DIV: A = −7, B = 2 → result −3 (`0xFFFF_FFFF_FFFF_FFFD`), `done_o` at E0+66. REM with the same operands → −1.
  - DIVU, B = 0, A = 0x1234 → `0xFFFF_FFFF_FFFF_FFFF` at E0+2. REMU with the same operands → 0x1234.
  - DIV: A = 0x8000_0000_0000_0000, B = −1 → A, with REM = 0. DIVW: A = 0x8000_0000, B = −1 → `0xFFFF_FFFF_8000_0000`.
  - MULH: A = −1, B = −1 → 0. MULHU with the same operands → `0xFFFF_FFFF_FFFF_FFFE`. MULW: A = 0x7FFF_FFFF, B = 2 → `0xFFFF_FFFF_FFFF_FFFE`.
    - With `MDU_FAST_MUL_EN`: latency 2.
    - Without it: DIVW/MULW latency 34.
  - `flush_i` at the 10th CALC cycle → IDLE on the next edge, no `done_o`. `start_i` + `flush_i` in the same IDLE cycle → no acceptance.
  - `start_i` toggled while busy → ignored; one `done_o` only. `stall_o` is high in the start cycle and drops in the `done_o` cycle.
